// File: rtl/chess_timer_pkg.sv
// Shared digit type, BCD limits, adjust-select encodings and small BCD helpers
// for the chess clock timer.
package chess_timer_pkg;

  typedef logic [3:0] digit_t;

  localparam digit_t SEC_UNITS_MAX = 4'd9;
  localparam digit_t SEC_TENS_MAX  = 4'd5;
  localparam digit_t MIN_UNITS_MAX = 4'd9;

  localparam logic [1:0] ADJ_SEC_UNITS = 2'd0;
  localparam logic [1:0] ADJ_SEC_TENS  = 2'd1;
  localparam logic [1:0] ADJ_MIN_UNITS = 2'd2;
  localparam logic [1:0] ADJ_MIN_TENS  = 2'd3;

  function automatic digit_t wrap_inc(input digit_t d, input digit_t lim);
    return (d >= lim) ? 4'd0 : d + 4'd1;
  endfunction

  function automatic digit_t wrap_dec(input digit_t d, input digit_t lim);
    return (d == 4'd0) ? lim : d - 4'd1;
  endfunction

  function automatic logic [6:0] bcd_to_bin(input digit_t tens, input digit_t units);
    return 7'(tens) * 7'd10 + 7'(units);
  endfunction

  function automatic digit_t bin_tens(input logic [6:0] b);
    return digit_t'(b / 7'd10);
  endfunction

  function automatic digit_t bin_units(input logic [6:0] b);
    return digit_t'(b % 7'd10);
  endfunction

endpackage

// File: rtl/chess_timer_bcd_if.sv
// Control inputs and MM:SS / flag outputs of one player's timer.
interface chess_timer_bcd_if;
  import chess_timer_pkg::*;

  logic       ce;
  logic       impulse;
  logic       load;
  logic       bonus;
  logic [1:0] adj_sel;
  logic       adj_up;
  logic       adj_down;
  digit_t     sec_units;
  digit_t     sec_tens;
  digit_t     min_units;
  digit_t     min_tens;
  logic       expired;
  logic       overflow;

  modport master (
    output ce, impulse, load, bonus, adj_sel, adj_up, adj_down,
    input  sec_units, sec_tens, min_units, min_tens, expired, overflow
  );

  modport slave (
    input  ce, impulse, load, bonus, adj_sel, adj_up, adj_down,
    output sec_units, sec_tens, min_units, min_tens, expired, overflow
  );

endinterface

// File: rtl/bcd_digit_counter.sv
// One BCD digit wrapping within 0..LIMIT; carry/borrow flag the wrap of this step.
module bcd_digit_counter
  import chess_timer_pkg::*;
#(
  parameter int unsigned LIMIT   = 9,
  parameter int unsigned RST_VAL = 0
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   inc,
  input  logic   dec,
  input  logic   load,
  input  digit_t load_val,
  output digit_t q,
  output logic   carry,
  output logic   borrow
);

  localparam digit_t Lim    = digit_t'(LIMIT);
  localparam digit_t RstVal = digit_t'(RST_VAL);

  digit_t q_q, q_d;
  logic   up, dn;

  assign up     = inc & ~dec & ~load;
  assign dn     = dec & ~inc & ~load;
  assign carry  = up & (q_q == Lim);
  assign borrow = dn & (q_q == 4'd0);

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = load_val;
    end else if (up) begin
      q_d = wrap_inc(q_q, Lim);
    end else if (dn) begin
      q_d = wrap_dec(q_q, Lim);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= RstVal;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/chess_timer_bcd.sv
// Per-player MM:SS BCD chess timer: countdown or stopwatch, Fischer bonus,
// preset load, per-digit adjust, expiry and overflow flags.
module chess_timer_bcd
  import chess_timer_pkg::*;
#(
  parameter bit          COUNT_DOWN  = 1'b1,
  parameter int unsigned MAX_MINUTES = 99,
  parameter int unsigned PRESET_MIN  = 5,
  parameter int unsigned BONUS_SEC   = 0
) (
  input logic              clk,
  input logic              rst_n,
  chess_timer_bcd_if.slave bus
);

  localparam logic [6:0] MaxMin      = 7'(MAX_MINUTES);
  localparam logic [6:0] BonusSec    = 7'(BONUS_SEC);
  localparam digit_t     MinTensMax  = digit_t'(MAX_MINUTES / 10);
  localparam digit_t     MinUnitsTop = digit_t'(MAX_MINUTES % 10);
  localparam digit_t     PresetTens  = digit_t'(PRESET_MIN / 10);
  localparam digit_t     PresetUnits = digit_t'(PRESET_MIN % 10);

  digit_t     su, st, mu, mt;
  digit_t     nsu, nst, nmu, nmt;
  digit_t     asu, ast, amu, amt;
  logic       carry_su, carry_st, carry_mu, carry_mt;
  logic       borrow_su, borrow_st, borrow_mu, borrow_mt;
  logic       load_all, step_up, step_dn;
  logic       expired_q, expired_d, overflow_q, overflow_d;
  logic [6:0] sec_bin, min_bin, bsec_sum, bsec, bmin;
  logic       bcarry, bsat, at_zero, at_one, at_max, run_adj, tick, adj_zero;
  logic       unused_chain;

  assign sec_bin = bcd_to_bin(st, su);
  assign min_bin = bcd_to_bin(mt, mu);
  assign at_zero = ({mt, mu, st, su} == 16'h0000);
  assign at_one  = ({mt, mu, st, su} == 16'h0001);
  assign at_max  = (min_bin == MaxMin) && (sec_bin == 7'd59);
  assign run_adj = ~bus.ce & (bus.adj_up | bus.adj_down);
  assign tick    = bus.impulse & bus.ce & ~expired_q;

  // Adjust touches one digit only; minutes above the maximum clamp the units digit.
  always_comb begin
    asu = su;
    ast = st;
    amu = mu;
    amt = mt;
    case (bus.adj_sel)
      ADJ_SEC_UNITS: asu = bus.adj_up ? wrap_inc(su, SEC_UNITS_MAX) : wrap_dec(su, SEC_UNITS_MAX);
      ADJ_SEC_TENS:  ast = bus.adj_up ? wrap_inc(st, SEC_TENS_MAX) : wrap_dec(st, SEC_TENS_MAX);
      ADJ_MIN_UNITS: amu = bus.adj_up ? wrap_inc(mu, MIN_UNITS_MAX) : wrap_dec(mu, MIN_UNITS_MAX);
      ADJ_MIN_TENS:  amt = bus.adj_up ? wrap_inc(mt, MinTensMax) : wrap_dec(mt, MinTensMax);
      default:       asu = su;
    endcase
    if ((amt == MinTensMax) && (amu > MinUnitsTop)) begin
      amu = MinUnitsTop;
    end
    adj_zero = ({amt, amu, ast, asu} == 16'h0000);
  end

  always_comb begin
    bsec_sum = sec_bin + BonusSec;
    bcarry   = (bsec_sum >= 7'd60);
    bsec     = bcarry ? bsec_sum - 7'd60 : bsec_sum;
    bmin     = min_bin + {6'd0, bcarry};
    bsat     = (bmin > MaxMin);
  end

  // One event per cycle: LOAD > adjust > BONUS > tick; losers are dropped.
  always_comb begin
    load_all   = 1'b0;
    step_up    = 1'b0;
    step_dn    = 1'b0;
    {nmt, nmu, nst, nsu} = 16'h0000;
    expired_d  = expired_q;
    overflow_d = 1'b0;
    if (bus.load) begin
      load_all  = 1'b1;
      nmt       = PresetTens;
      nmu       = PresetUnits;
      expired_d = 1'b0;
    end else if (run_adj) begin
      if (bus.adj_up ^ bus.adj_down) begin
        load_all  = 1'b1;
        {nmt, nmu, nst, nsu} = {amt, amu, ast, asu};
        expired_d = COUNT_DOWN & adj_zero;
      end
    end else if (bus.bonus) begin
      if ((BONUS_SEC != 0) && !expired_q) begin
        load_all = 1'b1;
        if (bsat) begin
          {nmt, nmu, nst, nsu} = {MinTensMax, MinUnitsTop, SEC_TENS_MAX, SEC_UNITS_MAX};
        end else begin
          {nmt, nmu, nst, nsu} = {bin_tens(bmin), bin_units(bmin), bin_tens(bsec),
                                  bin_units(bsec)};
        end
      end
    end else if (tick) begin
      if (COUNT_DOWN) begin
        if (at_zero) begin
          expired_d = 1'b1;
        end else begin
          step_dn   = 1'b1;
          expired_d = at_one;
        end
      end else if (at_max) begin
        load_all   = 1'b1;
        overflow_d = 1'b1;
      end else begin
        step_up = 1'b1;
      end
    end
  end

  bcd_digit_counter #(
    .LIMIT  (int'(SEC_UNITS_MAX)),
    .RST_VAL(0)
  ) u_sec_units (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc     (step_up),
    .dec     (step_dn),
    .load    (load_all),
    .load_val(nsu),
    .q       (su),
    .carry   (carry_su),
    .borrow  (borrow_su)
  );

  bcd_digit_counter #(
    .LIMIT  (int'(SEC_TENS_MAX)),
    .RST_VAL(0)
  ) u_sec_tens (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc     (carry_su),
    .dec     (borrow_su),
    .load    (load_all),
    .load_val(nst),
    .q       (st),
    .carry   (carry_st),
    .borrow  (borrow_st)
  );

  bcd_digit_counter #(
    .LIMIT  (int'(MIN_UNITS_MAX)),
    .RST_VAL(PRESET_MIN % 10)
  ) u_min_units (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc     (carry_st),
    .dec     (borrow_st),
    .load    (load_all),
    .load_val(nmu),
    .q       (mu),
    .carry   (carry_mu),
    .borrow  (borrow_mu)
  );

  bcd_digit_counter #(
    .LIMIT  (MAX_MINUTES / 10),
    .RST_VAL(PRESET_MIN / 10)
  ) u_min_tens (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc     (carry_mu),
    .dec     (borrow_mu),
    .load    (load_all),
    .load_val(nmt),
    .q       (mt),
    .carry   (carry_mt),
    .borrow  (borrow_mt)
  );

  // Wrap past the top and below 00:00 is handled by load_all, never by the chain.
  assign unused_chain = carry_mt | borrow_mt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      expired_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      expired_q  <= expired_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.sec_units = su;
  assign bus.sec_tens  = st;
  assign bus.min_units = mu;
  assign bus.min_tens  = mt;
  assign bus.expired   = expired_q;
  assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_chess_timer_bcd.sv
// Directed bench for two timer instances (countdown with bonus, stopwatch with small max).
module tb_chess_timer_bcd;
  import chess_timer_pkg::*;

  typedef struct packed {
    logic        inst;
    logic [15:0] mmss;
    logic        expired;
    logic        overflow;
  } exp_t;

  logic  clk = 1'b0;
  logic  rst_n;
  int    checks = 0;
  int    errors = 0;
  exp_t  sb_q[$];
  string tag_q[$];

  always #5 clk = ~clk;

  chess_timer_bcd_if bus_a ();
  chess_timer_bcd_if bus_b ();

  chess_timer_bcd #(
    .COUNT_DOWN (1'b1),
    .MAX_MINUTES(99),
    .PRESET_MIN (5),
    .BONUS_SEC  (30)
  ) dut_a (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_a)
  );

  chess_timer_bcd #(
    .COUNT_DOWN (1'b0),
    .MAX_MINUTES(9),
    .PRESET_MIN (9),
    .BONUS_SEC  (0)
  ) dut_b (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_b)
  );

  function automatic logic [15:0] mmss(input int secs);
    int m, s;
    m = secs / 60;
    s = secs % 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  task automatic clear_pulses();
    bus_a.impulse = 0; bus_a.load = 0; bus_a.bonus = 0; bus_a.adj_up = 0; bus_a.adj_down = 0;
    bus_b.impulse = 0; bus_b.load = 0; bus_b.bonus = 0; bus_b.adj_up = 0; bus_b.adj_down = 0;
  endtask

  task automatic expect_state(input string tag, input logic inst, input int secs,
                              input logic expd, input logic ovf);
    exp_t e;
    e.inst     = inst;
    e.mmss     = mmss(secs);
    e.expired  = expd;
    e.overflow = ovf;
    sb_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic drain();
    exp_t        e;
    string       t;
    logic [17:0] obs, req;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      t = tag_q.pop_front();
      if (e.inst) obs = {bus_b.min_tens, bus_b.min_units, bus_b.sec_tens, bus_b.sec_units,
                         bus_b.expired, bus_b.overflow};
      else        obs = {bus_a.min_tens, bus_a.min_units, bus_a.sec_tens, bus_a.sec_units,
                         bus_a.expired, bus_a.overflow};
      req = {e.mmss, e.expired, e.overflow};
      checks++;
      assert (obs === req) else begin
        errors++;
        $error("FAIL %s: observed %h exp=%b ovf=%b, expected %h exp=%b ovf=%b",
               t, obs[17:2], obs[1], obs[0], req[17:2], req[1], req[0]);
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
    clear_pulses();
    drain();
  endtask

  task automatic adj(input logic inst, input logic [1:0] sel, input logic up, input int n,
                     input string tag, input int secs, input logic expd);
    for (int k = 0; k < n; k++) begin
      if (inst) begin
        bus_b.adj_sel = sel; bus_b.adj_up = up; bus_b.adj_down = ~up;
      end else begin
        bus_a.adj_sel = sel; bus_a.adj_up = up; bus_a.adj_down = ~up;
      end
      if (k == n - 1) expect_state(tag, inst, secs, expd, 1'b0);
      cycle();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus_a.ce = 0; bus_a.adj_sel = 0;
    bus_b.ce = 0; bus_b.adj_sel = 0;
    clear_pulses();
    @(negedge clk);
    expect_state("reset_a", 0, 300, 0, 0);
    expect_state("reset_b", 1, 540, 0, 0);
    drain();
    rst_n = 1'b1;

    // Full countdown from 05:00
    bus_a.load = 1; expect_state("load_a", 0, 300, 0, 0); cycle();
    bus_a.ce = 1;
    for (int i = 1; i <= 300; i++) begin
      bus_a.impulse = 1;
      expect_state("countdown", 0, 300 - i, (i == 300), 0);
      cycle();
    end

    // Expired holds until LOAD
    bus_a.impulse = 1; expect_state("expired_tick", 0, 0, 1, 0); cycle();
    bus_a.bonus = 1;   expect_state("expired_bonus", 0, 0, 1, 0); cycle();
    bus_a.load = 1;    expect_state("reload_running", 0, 300, 0, 0); cycle();

    // Digit adjust
    bus_a.ce = 0;
    adj(0, ADJ_SEC_TENS, 1, 5, "sec_tens_to_5", 350, 0);
    adj(0, ADJ_SEC_TENS, 1, 1, "sec_tens_wrap", 300, 0);
    adj(0, ADJ_SEC_UNITS, 0, 1, "sec_units_wrap", 309, 0);
    bus_a.adj_up = 1; bus_a.adj_down = 1;
    expect_state("adj_both", 0, 309, 0, 0); cycle();
    bus_a.ce = 1;
    adj(0, ADJ_SEC_UNITS, 1, 1, "adj_running_up", 309, 0);
    adj(0, ADJ_SEC_TENS, 0, 1, "adj_running_down", 309, 0);

    // Bonus
    bus_a.ce = 0; bus_a.load = 1; expect_state("load_c", 0, 300, 0, 0); cycle();
    adj(0, ADJ_MIN_UNITS, 0, 3, "to_02_00", 120, 0);
    adj(0, ADJ_SEC_TENS, 1, 4, "to_02_40", 160, 0);
    adj(0, ADJ_SEC_UNITS, 1, 5, "to_02_45", 165, 0);
    bus_a.bonus = 1; expect_state("bonus_carry", 0, 195, 0, 0); cycle();
    bus_a.ce = 1; bus_a.bonus = 1; bus_a.impulse = 1;
    expect_state("bonus_beats_tick", 0, 225, 0, 0); cycle();
    bus_a.ce = 0; bus_a.load = 1; expect_state("load_d", 0, 300, 0, 0); cycle();
    adj(0, ADJ_MIN_TENS, 0, 1, "min_tens_wrap", 95 * 60, 0);
    adj(0, ADJ_MIN_UNITS, 1, 4, "to_99_00", 99 * 60, 0);
    adj(0, ADJ_SEC_TENS, 1, 5, "to_99_50", 99 * 60 + 50, 0);
    bus_a.bonus = 1; expect_state("bonus_saturate", 0, 99 * 60 + 59, 0, 0); cycle();
    bus_a.bonus = 1; expect_state("bonus_at_max", 0, 99 * 60 + 59, 0, 0); cycle();
    bus_a.load = 1; expect_state("load_e", 0, 300, 0, 0); cycle();
    adj(0, ADJ_MIN_UNITS, 0, 5, "adj_to_zero", 0, 1);
    adj(0, ADJ_MIN_UNITS, 1, 1, "adj_nonzero", 60, 0);

    // Stopwatch wrap at 09:59
    bus_b.load = 1; expect_state("load_b", 1, 540, 0, 0); cycle();
    adj(1, ADJ_SEC_TENS, 0, 1, "b_09_50", 590, 0);
    adj(1, ADJ_SEC_UNITS, 0, 2, "b_09_58", 598, 0);
    bus_b.impulse = 1; expect_state("b_tick_ce0", 1, 598, 0, 0); cycle();
    bus_b.ce = 1;
    bus_b.impulse = 1; expect_state("b_09_59", 1, 599, 0, 0); cycle();
    bus_b.impulse = 1; expect_state("b_overflow", 1, 0, 0, 1); cycle();
    expect_state("b_ovf_pulse_end", 1, 0, 0, 0); cycle();

    // Asynchronous reset mid-count at 03:17
    bus_a.ce = 1; bus_a.load = 1; expect_state("load_f", 0, 300, 0, 0); cycle();
    for (int i = 1; i <= 103; i++) begin
      bus_a.impulse = 1;
      expect_state("count_to_03_17", 0, 300 - i, 0, 0);
      cycle();
    end
    #2 rst_n = 1'b0;
    #1;
    expect_state("async_reset_a", 0, 300, 0, 0);
    expect_state("async_reset_b", 1, 540, 0, 0);
    drain();
    @(negedge clk);
    rst_n = 1'b1;
    bus_a.ce = 0; bus_b.ce = 0;
    expect_state("post_reset_a", 0, 300, 0, 0);
    expect_state("post_reset_b", 1, 540, 0, 0);
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
